pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter with a single-outstanding instruction fetch engine.
// imem_ack/imem_data are registered before use, so every output is a flop.
module pc_fetch_unit #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int unsigned TIMEOUT      = 15,
   parameter logic [15:0] NOP_WORD     = 16'h4303
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_inc,
   input  logic        en_pc_2,
   input  logic        branch_en,
   input  logic [9:0]  pc_offset,
   input  logic        fetch_req,
   input  logic [15:0] imem_data,
   input  logic        imem_ack,
   output logic [15:0] imem_addr,
   output logic        imem_rd,
   output logic [15:0] instruction,
   output logic        inst_valid,
   output logic [15:0] pc,
   output logic        busy,
   output logic        fetch_err
);

   typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

   localparam logic [15:0] PC_RESET = {RESET_VECTOR[15:1], 1'b0};
   localparam logic [7:0]  TMO      = 8'(TIMEOUT);

   state_t      r_state, w_state_nxt;
   logic [15:0] r_pc, w_pc_nxt, w_br_off;
   logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [15:0] r_addr, w_addr_nxt;
   logic [15:0] r_inst, w_inst_nxt;
   logic [15:0] r_data, w_data_nxt;
   logic        r_rd, w_rd_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_err, w_err_nxt;
   logic        r_ack, w_ack_nxt;

   // Word offset scaled to bytes; result stays even because r_pc is even.
   assign w_br_off  = {{5{pc_offset[9]}}, pc_offset, 1'b0};
   assign w_cnt_inc = r_cnt + 8'd1;

   always_comb begin
      w_pc_nxt = r_pc;
      if (pc_inc) begin
         if (branch_en)
            w_pc_nxt = r_pc + 16'd2 + w_br_off;
         else if (en_pc_2)
            w_pc_nxt = r_pc + 16'd2;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_addr_nxt  = r_addr;
      w_inst_nxt  = r_inst;
      w_data_nxt  = r_data;
      w_rd_nxt    = r_rd;
      w_valid_nxt = 1'b0;
      w_err_nxt   = r_err;
      w_ack_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            w_rd_nxt = 1'b0;
            if (fetch_req) begin
               w_state_nxt = READ;
               w_addr_nxt  = r_pc;
               w_err_nxt   = 1'b0;
               w_cnt_nxt   = '0;
               w_rd_nxt    = 1'b1;
            end
         end
         READ: begin
            w_rd_nxt = 1'b1;
            if (r_ack) begin
               w_state_nxt = DONE;
               w_inst_nxt  = r_data;
               w_valid_nxt = 1'b1;
               w_rd_nxt    = 1'b0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (imem_ack) begin
                  w_ack_nxt  = 1'b1;
                  w_data_nxt = imem_data;
               end else if (w_cnt_inc == TMO) begin
                  // An ack on this same cycle would have taken the branch above.
                  w_state_nxt = DONE;
                  w_inst_nxt  = NOP_WORD;
                  w_err_nxt   = 1'b1;
                  w_valid_nxt = 1'b1;
                  w_rd_nxt    = 1'b0;
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_rd_nxt    = 1'b0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_rd_nxt    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc    <= PC_RESET;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_inst  <= '0;
         r_data  <= '0;
         r_rd    <= 1'b0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         r_pc    <= w_pc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_addr  <= w_addr_nxt;
         r_inst  <= w_inst_nxt;
         r_data  <= w_data_nxt;
         r_rd    <= w_rd_nxt;
         r_valid <= w_valid_nxt;
         r_err   <= w_err_nxt;
         r_ack   <= w_ack_nxt;
      end
   end

   assign pc          = r_pc;
   assign imem_addr   = r_addr;
   assign imem_rd     = r_rd;
   assign instruction = r_inst;
   assign inst_valid  = r_valid;
   assign fetch_err   = r_err;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed corner cases, then random
// traffic against a latency-rule model of the PC and fetch transaction.
module tb_pc_fetch_unit;

   localparam logic [15:0] RV  = 16'h0000;
   localparam int          TMO = 15;
   localparam logic [15:0] NOP = 16'h4303;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_inc, en_pc_2, branch_en, fetch_req, imem_ack;
   logic [9:0]  pc_offset;
   logic [15:0] imem_data;
   logic [15:0] imem_addr, instruction, pc;
   logic        imem_rd, inst_valid, busy, fetch_err;

   int n_cmp = 0;
   int n_err = 0;
   int n_valid = 0;

   // Model state: PC as plain integer, fetch tracked as edges since acceptance.
   int          m_pc;
   logic [15:0] m_addr, m_inst, m_data;
   logic        m_err, m_active;
   int          m_t, m_ackk;

   pc_fetch_unit #(
      .RESET_VECTOR(RV),
      .TIMEOUT(TMO),
      .NOP_WORD(NOP)
   ) dut (
      .clk(clk), .rst(rst), .pc_inc(pc_inc), .en_pc_2(en_pc_2),
      .branch_en(branch_en), .pc_offset(pc_offset), .fetch_req(fetch_req),
      .imem_data(imem_data), .imem_ack(imem_ack), .imem_addr(imem_addr),
      .imem_rd(imem_rd), .instruction(instruction), .inst_valid(inst_valid),
      .pc(pc), .busy(busy), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic int sext10(input logic [9:0] v);
      return v[9] ? int'(v) - 1024 : int'(v);
   endfunction

   task automatic model_reset();
      m_pc = int'(RV) & 'hFFFE;
      m_addr = '0; m_inst = '0; m_data = '0;
      m_err = 1'b0; m_active = 1'b0; m_t = 0; m_ackk = 0;
   endtask

   task automatic model_edge();
      int old_pc;
      old_pc = m_pc;
      if (pc_inc) begin
         if (branch_en)    m_pc = (m_pc + 2 + 2 * sext10(pc_offset)) & 'hFFFF;
         else if (en_pc_2) m_pc = (m_pc + 2) & 'hFFFF;
      end
      if (!m_active) begin
         if (fetch_req) begin
            m_active = 1'b1; m_t = 0; m_ackk = 0;
            m_addr = 16'(old_pc); m_err = 1'b0;
         end
      end else begin
         m_t++;
         if (m_ackk == 0 && m_t <= TMO && imem_ack) begin
            m_ackk = m_t; m_data = imem_data;
         end
         if (m_ackk != 0 && m_t == m_ackk + 1) m_inst = m_data;
         if (m_ackk == 0 && m_t == TMO) begin
            m_inst = NOP; m_err = 1'b1;
         end
         if ((m_ackk != 0 && m_t == m_ackk + 2) || (m_ackk == 0 && m_t == TMO + 1))
            m_active = 1'b0;
      end
   endtask

   task automatic check_all();
      logic e_rd, e_valid;
      e_rd    = m_active && ((m_ackk == 0) ? (m_t < TMO) : (m_t <= m_ackk));
      e_valid = m_active && ((m_ackk != 0) ? (m_t == m_ackk + 1) : (m_t == TMO));
      chk("pc",          pc,          16'(m_pc));
      chk("imem_addr",   imem_addr,   m_addr);
      chk("imem_rd",     {15'd0, imem_rd},    {15'd0, e_rd});
      chk("instruction", instruction, m_inst);
      chk("inst_valid",  {15'd0, inst_valid}, {15'd0, e_valid});
      chk("busy",        {15'd0, busy},       {15'd0, m_active});
      chk("fetch_err",   {15'd0, fetch_err},  {15'd0, m_err});
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_edge();
      @(negedge clk);
      if (inst_valid) n_valid++;
      check_all();
   endtask

   task automatic idle_inputs();
      pc_inc = 0; en_pc_2 = 0; branch_en = 0; pc_offset = '0;
      fetch_req = 0; imem_ack = 0; imem_data = '0;
   endtask

   task automatic pc_step(input logic e2, input logic br, input logic [9:0] off);
      pc_inc = 1; en_pc_2 = e2; branch_en = br; pc_offset = off;
      tick();
      pc_inc = 0; en_pc_2 = 0; branch_en = 0;
   endtask

   initial begin
      int base;
      int ack_pct;
      rst = 1'b0;
      idle_inputs();
      model_reset();
      tick(); tick();
      chk("rst_pc", pc, 16'h0000);
      chk("rst_instr", instruction, 16'h0000);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      @(negedge clk); rst = 1'b1;

      // Fetch with ack two cycles after the request is taken.
      base = n_valid;
      fetch_req = 1; tick(); fetch_req = 0;
      tick();
      imem_ack = 1; imem_data = 16'h5402; tick(); imem_ack = 0; imem_data = '0;
      repeat (3) tick();
      chk("f1_addr", imem_addr, 16'h0000);
      chk("f1_instr", instruction, 16'h5402);
      chk("f1_err", {15'd0, fetch_err}, 16'd0);
      chk("f1_pulses", 16'(n_valid - base), 16'd1);

      // PC arithmetic: reach 0x0010, then step, branch and hold.
      pc_step(0, 1, 10'd7);
      chk("pc_0010", pc, 16'h0010);
      pc_step(1, 0, 10'd0);
      chk("pc_plus2", pc, 16'h0012);
      pc_step(0, 1, 10'h3FE);
      pc_step(1, 1, 10'h3FE);
      chk("pc_branch_prio", pc, 16'h000E);
      pc_step(0, 0, 10'd0);
      chk("pc_hold", pc, 16'h000E);
      pc_step(0, 1, 10'h3F7);
      chk("pc_fffe", pc, 16'hFFFE);
      pc_step(1, 0, 10'd0);
      chk("pc_wrap", pc, 16'h0000);

      // Timeout abort, then a fresh fetch clears the error.
      base = n_valid;
      fetch_req = 1; tick(); fetch_req = 0;
      repeat (TMO + 2) tick();
      chk("to_instr", instruction, NOP);
      chk("to_err", {15'd0, fetch_err}, 16'd1);
      chk("to_pulses", 16'(n_valid - base), 16'd1);

      // Ack on the first READ cycle while a second request arrives.
      base = n_valid;
      pc_inc = 1; en_pc_2 = 1;
      fetch_req = 1; tick(); fetch_req = 1; pc_inc = 0; en_pc_2 = 0;
      chk("f2_err_clr", {15'd0, fetch_err}, 16'd0);
      chk("f2_addr_prepc", imem_addr, 16'h0000);
      imem_ack = 1; imem_data = 16'h1234; tick();
      imem_ack = 0; fetch_req = 0;
      repeat (4) tick();
      chk("f2_instr", instruction, 16'h1234);
      chk("f2_pulses", 16'(n_valid - base), 16'd1);

      // Ack arriving on the very cycle the timeout would fire.
      fetch_req = 1; tick(); fetch_req = 0;
      repeat (TMO - 1) tick();
      imem_ack = 1; imem_data = 16'hA5C3; tick(); imem_ack = 0;
      repeat (3) tick();
      chk("late_ack_err", {15'd0, fetch_err}, 16'd0);
      chk("late_ack_instr", instruction, 16'hA5C3);

      // Asynchronous reset in the middle of a READ.
      fetch_req = 1; tick(); fetch_req = 0;
      tick();
      #2 rst = 1'b0;
      #1 chk("rst_async_rd", {15'd0, imem_rd}, 16'd0);
      model_reset();
      tick();
      rst = 1'b1;
      tick();
      imem_ack = 1; imem_data = 16'hBEEF; tick(); imem_ack = 0;
      tick();
      chk("rst_ack_ignored", instruction, 16'h0000);

      // Random traffic.
      ack_pct = 30;
      for (int i = 0; i < 1000; i++) begin
         if (i % 64 == 0) ack_pct = ($urandom_range(0, 1) == 0) ? 3 : 35;
         fetch_req = ($urandom_range(0, 99) < 30);
         pc_inc    = ($urandom_range(0, 99) < 50);
         en_pc_2   = 1'($urandom_range(0, 1));
         branch_en = ($urandom_range(0, 99) < 30);
         pc_offset = 10'($urandom);
         imem_ack  = ($urandom_range(0, 99) < ack_pct);
         imem_data = 16'($urandom);
         tick();
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1'b0;
            #1 model_reset();
            check_all();
            #1 rst = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
